// File: rtl/mesh_inject_arbiter.sv
// mesh_inject_arbiter: round-robin scheduler that merges num_src FWFT packet
// sources into one output FIFO feeding a mesh terminal injection port.
// The FIFO presents the same FWFT pending/data/pop handshake to the mesh side.
module mesh_inject_arbiter #(
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4,
  parameter int num_src    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [num_src-1:0]           src_pndng,
  input  logic [num_src*pckg_sz-1:0]   src_data,
  output logic [num_src-1:0]           src_pop,
  input  logic                         hold,
  output logic                         mesh_pndng,
  output logic [pckg_sz-1:0]           mesh_data,
  input  logic                         mesh_pop,
  output logic [$clog2(num_src)-1:0]   grant_id,
  output logic                         fifo_full,
  output logic [15:0]                  pkt_count
);

  localparam int gid_w = $clog2(num_src);
  localparam int ptr_w = $clog2(fifo_depth);
  localparam int cnt_w = ptr_w + 1;

  logic [pckg_sz-1:0] mem_q [fifo_depth];
  logic [pckg_sz-1:0] mem_d [fifo_depth];
  logic [ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
  logic [cnt_w-1:0]   count_q, count_d;
  logic [gid_w-1:0]   last_grant_q, last_grant_d;
  logic [15:0]        pkt_count_q, pkt_count_d;

  logic               winner_found;
  logic [gid_w-1:0]   winner_idx;
  logic [pckg_sz-1:0] winner_data;
  logic               full;
  logic               push;
  logic               pop;

  assign full = (count_q == cnt_w'(fifo_depth));

  // Round-robin search starting just after the last winner; scanning from the
  // farthest candidate back lets the nearest pending source overwrite the pick.
  always_comb begin
    int idx;
    idx          = 0;
    winner_found = 1'b0;
    winner_idx   = '0;
    for (int k = num_src; k >= 1; k--) begin
      idx = int'(last_grant_q) + k;
      if (idx >= num_src) idx = idx - num_src;
      if (src_pndng[gid_w'(idx)]) begin
        winner_found = 1'b1;
        winner_idx   = gid_w'(idx);
      end
    end
  end

  // Head packet of the winning source.
  always_comb begin
    winner_data = '0;
    for (int i = 0; i < num_src; i++) begin
      if (winner_idx == gid_w'(i)) winner_data = src_data[i*pckg_sz +: pckg_sz];
    end
  end

  // Grant/pop decode and next-state computation; reset gates the grant so
  // src_pop falls as soon as reset asserts.
  always_comb begin
    push         = reset && !hold && !full && winner_found;
    pop          = mesh_pop && (count_q != '0);
    src_pop      = push ? (num_src'(1) << winner_idx) : '0;

    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    pkt_count_d  = pkt_count_q;

    if (push) begin
      mem_d[wr_ptr_q] = winner_data;
      wr_ptr_d        = wr_ptr_q + ptr_w'(1);
      last_grant_d    = winner_idx;
      if (pkt_count_q != 16'hFFFF) pkt_count_d = pkt_count_q + 16'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + ptr_w'(1);

    if (push && !pop)      count_d = count_q + cnt_w'(1);
    else if (!push && pop) count_d = count_q - cnt_w'(1);
  end

  // State registers; last_grant resets to the top index so source 0 wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < fifo_depth; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= gid_w'(num_src - 1);
      pkt_count_q  <= '0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign mesh_pndng = (count_q != '0);
  assign mesh_data  = mem_q[rd_ptr_q];
  assign fifo_full  = full;
  assign grant_id   = last_grant_q;
  assign pkt_count  = pkt_count_q;

endmodule
